// File: rtl/jtkcpu_intctl_pkg.sv
// Shared constants and types for the jtkcpu interrupt controller.
package jtkcpu_intctl_pkg;

  localparam int unsigned CcF = 6;
  localparam int unsigned CcI = 4;

  localparam logic [2:0] VecNmi  = 3'd6;
  localparam logic [2:0] VecFirq = 3'd3;
  localparam logic [2:0] VecIrq  = 3'd4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StSync = 2'd2
  } state_e;

  typedef struct packed {
    logic       nmi;
    logic       firq;
    logic       irq;
    logic [2:0] vec;
  } req_t;

  // Fixed priority NMI > FIRQ > IRQ, one-hot result with matching vector code.
  function automatic req_t arbitrate(input logic p_nmi, input logic p_firq, input logic p_irq);
    req_t r;
    r = '0;
    if (p_nmi) begin
      r.nmi = 1'b1;
      r.vec = VecNmi;
    end else if (p_firq) begin
      r.firq = 1'b1;
      r.vec  = VecFirq;
    end else if (p_irq) begin
      r.irq = 1'b1;
      r.vec = VecIrq;
    end
    return r;
  endfunction

endpackage

// File: rtl/jtkcpu_intctl_if.sv
// Pin and ucode-side signals of the interrupt controller.
interface jtkcpu_intctl_if;
  logic       cen;
  logic       nmi_n;
  logic       firq_n;
  logic       irq_n;
  logic [7:0] cc;
  logic       s_loaded;
  logic       int_en;
  logic       int_ack;
  logic       sync_wait;
  logic       nmi;
  logic       firq;
  logic       irq;
  logic [2:0] vec;
  logic       sync_done;

  modport slave (
    input  cen, nmi_n, firq_n, irq_n, cc, s_loaded, int_en, int_ack, sync_wait,
    output nmi, firq, irq, vec, sync_done
  );

  modport master (
    output cen, nmi_n, firq_n, irq_n, cc, s_loaded, int_en, int_ack, sync_wait,
    input  nmi, firq, irq, vec, sync_done
  );
endinterface

// File: rtl/jtkcpu_intctl_intsync.sv
// Pin sampling, NMI falling-edge detection, NMI arming and the NMI latch.
module jtkcpu_intctl_intsync #(
  parameter bit NMI_ARMED = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_cen,
  input  logic i_nmi_n,
  input  logic i_firq_n,
  input  logic i_irq_n,
  input  logic i_s_loaded,
  input  logic i_nmi_clr,
  output logic o_nmi_lat,
  output logic o_firq_s,
  output logic o_irq_s
);

  logic r_nmi_s;
  logic r_firq_s;
  logic r_irq_s;
  logic r_armed;
  logic r_nmi_lat;
  logic w_nmi_edge;

  // Uses the old armed value, so an s_loaded on the edge's own cen does not accept it.
  assign w_nmi_edge = r_armed & r_nmi_s & ~i_nmi_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_nmi_s   <= 1'b1;
      r_firq_s  <= 1'b1;
      r_irq_s   <= 1'b1;
      r_armed   <= NMI_ARMED;
      r_nmi_lat <= 1'b0;
    end else if (i_cen) begin
      r_nmi_s  <= i_nmi_n;
      r_firq_s <= i_firq_n;
      r_irq_s  <= i_irq_n;
      r_armed  <= r_armed | i_s_loaded;
      if (w_nmi_edge) begin
        r_nmi_lat <= 1'b1;
      end else if (i_nmi_clr) begin
        r_nmi_lat <= 1'b0;
      end
    end
  end

  assign o_nmi_lat = r_nmi_lat;
  assign o_firq_s  = r_firq_s;
  assign o_irq_s   = r_irq_s;

endmodule

// File: rtl/jtkcpu_intctl.sv
// Interrupt request source for the jtkcpu ucode: masking, NMI>FIRQ>IRQ arbitration,
// request hold until acknowledge, and SYNC release.
module jtkcpu_intctl
  import jtkcpu_intctl_pkg::*;
#(
  parameter bit NMI_ARMED = 1'b0
) (
  input logic            clk,
  input logic            rst,
  jtkcpu_intctl_if.slave bus
);

  logic   w_nmi_lat;
  logic   w_firq_s;
  logic   w_irq_s;
  logic   w_nmi_clr;
  logic   w_p_nmi;
  logic   w_p_firq;
  logic   w_p_irq;
  logic   w_src_any;
  logic   w_unused_cc;
  state_e r_state;
  state_e w_state_nxt;
  req_t   r_req;
  req_t   w_req_nxt;
  logic   r_sync_done;
  logic   w_sync_done_nxt;

  jtkcpu_intctl_intsync #(
    .NMI_ARMED (NMI_ARMED)
  ) u_intsync (
    .clk        (clk),
    .rst        (rst),
    .i_cen      (bus.cen),
    .i_nmi_n    (bus.nmi_n),
    .i_firq_n   (bus.firq_n),
    .i_irq_n    (bus.irq_n),
    .i_s_loaded (bus.s_loaded),
    .i_nmi_clr  (w_nmi_clr),
    .o_nmi_lat  (w_nmi_lat),
    .o_firq_s   (w_firq_s),
    .o_irq_s    (w_irq_s)
  );

  assign w_p_nmi     = w_nmi_lat;
  assign w_p_firq    = ~w_firq_s & ~bus.cc[CcF];
  assign w_p_irq     = ~w_irq_s & ~bus.cc[CcI];
  // SYNC is released by any active source regardless of the CC masks.
  assign w_src_any   = w_nmi_lat | ~w_firq_s | ~w_irq_s;
  assign w_unused_cc = ^{bus.cc[7], bus.cc[5], bus.cc[3:0]};

  always_comb begin
    w_state_nxt     = r_state;
    w_req_nxt       = r_req;
    w_sync_done_nxt = 1'b0;
    w_nmi_clr       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.sync_wait) begin
          w_state_nxt = StSync;
        end else if (bus.int_en && (w_p_nmi || w_p_firq || w_p_irq)) begin
          w_state_nxt = StReq;
          w_req_nxt   = arbitrate(w_p_nmi, w_p_firq, w_p_irq);
        end
      end
      StReq: begin
        if (bus.int_ack) begin
          w_state_nxt = StIdle;
          w_req_nxt   = '0;
          w_nmi_clr   = r_req.nmi;
        end
      end
      StSync: begin
        if (w_src_any) begin
          w_state_nxt     = StIdle;
          w_sync_done_nxt = 1'b1;
        end else if (!bus.sync_wait) begin
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_req_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_req       <= '0;
      r_sync_done <= 1'b0;
    end else if (bus.cen) begin
      r_state     <= w_state_nxt;
      r_req       <= w_req_nxt;
      r_sync_done <= w_sync_done_nxt;
    end
  end

  assign bus.nmi       = r_req.nmi;
  assign bus.firq      = r_req.firq;
  assign bus.irq       = r_req.irq;
  assign bus.vec       = r_req.vec;
  assign bus.sync_done = r_sync_done;

endmodule

// File: tb/tb_jtkcpu_intctl.sv
// Directed plus random bench for jtkcpu_intctl against a behavioural interrupt model.
module tb_jtkcpu_intctl;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: which interrupt is being served (0 none, 1 NMI, 2 FIRQ, 3 IRQ).
  bit m_nmi_s, m_firq_s, m_irq_s, m_lat, m_armed, m_in_sync, m_pulse;
  int m_granted;

  jtkcpu_intctl_if bus ();

  jtkcpu_intctl #(
    .NMI_ARMED (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] model_out();
    logic [6:0] o;
    case (m_granted)
      1:       o = 7'b100_110_0;
      2:       o = 7'b010_011_0;
      3:       o = 7'b001_100_0;
      default: o = 7'b000_000_0;
    endcase
    o[0] = m_pulse;
    return o;
  endfunction

  task automatic model_edge();
    bit edge_n, src;
    int win;
    if (rst) begin
      m_nmi_s = 1; m_firq_s = 1; m_irq_s = 1; m_lat = 0; m_armed = 0;
      m_granted = 0; m_in_sync = 0; m_pulse = 0;
      return;
    end
    if (!bus.cen) return;
    edge_n = m_armed && m_nmi_s && !bus.nmi_n;
    src    = m_lat || !m_firq_s || !m_irq_s;
    win    = m_lat ? 1 : (!m_firq_s && !bus.cc[6]) ? 2 : (!m_irq_s && !bus.cc[4]) ? 3 : 0;
    m_pulse = 0;
    if (m_granted != 0) begin
      if (bus.int_ack) begin
        if (m_granted == 1) m_lat = 0;
        m_granted = 0;
      end
    end else if (m_in_sync) begin
      if (src) begin
        m_pulse   = 1;
        m_in_sync = 0;
      end else if (!bus.sync_wait) begin
        m_in_sync = 0;
      end
    end else if (bus.sync_wait) begin
      m_in_sync = 1;
    end else if (bus.int_en && win != 0) begin
      m_granted = win;
    end
    if (edge_n) m_lat = 1;
    m_nmi_s  = bus.nmi_n;
    m_firq_s = bus.firq_n;
    m_irq_s  = bus.irq_n;
    m_armed  = m_armed | bus.s_loaded;
  endtask

  function automatic logic [6:0] observed();
    return {bus.nmi, bus.firq, bus.irq, bus.vec, bus.sync_done};
  endfunction

  task automatic check_model(input string tag);
    logic [6:0] obs, exp;
    logic       ok;
    obs = observed();
    exp = model_out();
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
    ok = $onehot0({bus.nmi, bus.firq, bus.irq}) &&
         ((bus.nmi || bus.firq || bus.irq) || (bus.vec == 3'd0));
    n_vec++;
    assert (ok === 1'b1) else begin
      n_err++;
      $error("FAIL %s_onehot: observed %b expected one-hot with vec=0 when idle", tag, obs);
    end
  endtask

  task automatic expect_const(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = observed();
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  localparam logic [6:0] ONone = 7'b000_000_0;
  localparam logic [6:0] ONmi  = 7'b100_110_0;
  localparam logic [6:0] OFirq = 7'b010_011_0;
  localparam logic [6:0] OIrq  = 7'b001_100_0;
  localparam logic [6:0] OSync = 7'b000_000_1;

  initial begin
    rst = 1'b1;
    bus.cen = 1'b1; bus.nmi_n = 1'b1; bus.firq_n = 1'b1; bus.irq_n = 1'b1;
    bus.cc = 8'h00; bus.s_loaded = 1'b0; bus.int_en = 1'b0; bus.int_ack = 1'b0;
    bus.sync_wait = 1'b0;
    m_nmi_s = 1; m_firq_s = 1; m_irq_s = 1; m_lat = 0; m_armed = 0;
    m_granted = 0; m_in_sync = 0; m_pulse = 0;
    tick("reset"); tick("reset");
    expect_const("reset_state", ONone);
    rst = 1'b0;

    // Arming
    bus.int_en = 1'b1;
    bus.nmi_n = 1'b0; tick("arm_edge"); tick("arm_wait");
    expect_const("unarmed_edge", ONone);
    bus.nmi_n = 1'b1; bus.s_loaded = 1'b1; tick("arm_load");
    bus.s_loaded = 1'b0; tick("arm_idle");
    bus.nmi_n = 1'b0; tick("armed_edge"); tick("armed_req");
    expect_const("armed_nmi", ONmi);
    bus.int_ack = 1'b1; tick("nmi_ack");
    expect_const("nmi_ack", ONone);
    bus.int_ack = 1'b0; bus.nmi_n = 1'b1; tick("nmi_idle");

    // Masking
    bus.cc = 8'h10; bus.irq_n = 1'b0; tick("irq_s"); tick("irq_m");
    expect_const("irq_masked", ONone);
    bus.cc = 8'h00; tick("irq_req");
    expect_const("irq_unmasked", OIrq);
    bus.int_ack = 1'b1; bus.irq_n = 1'b1; tick("irq_ack");
    expect_const("irq_ack", ONone);
    bus.int_ack = 1'b0; tick("irq_idle");

    // Priority
    bus.int_en = 1'b0; bus.irq_n = 1'b0; bus.firq_n = 1'b0; bus.nmi_n = 1'b0; tick("prio_s");
    bus.int_en = 1'b1; tick("prio_nmi");
    expect_const("prio_nmi", ONmi);
    bus.int_ack = 1'b1; tick("prio_ack1");
    bus.int_ack = 1'b0; tick("prio_firq");
    expect_const("prio_firq", OFirq);
    bus.int_ack = 1'b1; bus.firq_n = 1'b1; tick("prio_ack2");
    bus.int_ack = 1'b0; tick("prio_irq");
    expect_const("prio_irq", OIrq);
    bus.int_ack = 1'b1; bus.irq_n = 1'b1; bus.nmi_n = 1'b1; tick("prio_ack3");
    bus.int_ack = 1'b0; tick("prio_done");
    expect_const("prio_done", ONone);

    // Hold: no preemption, no withdrawal
    bus.firq_n = 1'b0; tick("hold_s"); tick("hold_req");
    expect_const("hold_firq", OFirq);
    bus.firq_n = 1'b1; bus.nmi_n = 1'b0; tick("hold_edge"); tick("hold_keep");
    expect_const("hold_keep", OFirq);
    bus.int_ack = 1'b1; tick("hold_ack");
    bus.int_ack = 1'b0; tick("hold_nmi");
    expect_const("hold_nmi", ONmi);
    bus.int_ack = 1'b1; bus.nmi_n = 1'b1; tick("hold_ack2");
    bus.int_ack = 1'b0;

    // SYNC released by a masked source
    bus.int_en = 1'b0; bus.cc = 8'h50; bus.irq_n = 1'b0; bus.sync_wait = 1'b1; tick("sync_in");
    tick("sync_rel");
    expect_const("sync_done", OSync);
    bus.sync_wait = 1'b0; tick("sync_after");
    expect_const("sync_after", ONone);
    bus.irq_n = 1'b1; bus.cc = 8'h00; tick("sync_idle");

    // cen hold, then reset mid-request
    bus.int_en = 1'b1; bus.cen = 1'b0; bus.nmi_n = 1'b0; tick("cen0_a"); tick("cen0_b");
    expect_const("cen_hold", ONone);
    bus.cen = 1'b1; tick("cen1_edge"); tick("cen1_req");
    expect_const("cen_resume", ONmi);
    rst = 1'b1; tick("rst_req");
    expect_const("rst_req", ONone);
    rst = 1'b0; bus.nmi_n = 1'b1; tick("rst_idle");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst           = ($urandom_range(0, 99) == 0);
      bus.cen       = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) bus.nmi_n  = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 5) == 0) bus.firq_n = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 5) == 0) bus.irq_n  = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 7) == 0) bus.cc     = 8'($urandom_range(0, 255));
      bus.s_loaded  = ($urandom_range(0, 19) == 0);
      bus.int_en    = ($urandom_range(0, 1) == 1);
      bus.int_ack   = ($urandom_range(0, 3) == 0);
      bus.sync_wait = ($urandom_range(0, 7) == 0);
      tick("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
